image_sequencer: RTL and testbench

Frame-synchronous controller that generates the one-hot image_select for the screensaver display path. It auto-advances through the stored images every FRAMES_PER_IMAGE frames, and accepts next/prev/direct-load requests from board buttons and switches. Every change is deferred to the start of a vertical sync pulse, so the image never changes mid-frame. It sits between the button/switch front-end and the screensaver's image_select_i input, and taps the VGA timer's vsync.

---
 rtl/image_sequencer.sv | 153 +++++++++++++++
 tb/tb_image_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_sequencer.sv
// Frame-synchronous one-hot image selector for the screensaver path.
// Auto-advances every FRAMES_PER_IMAGE frames; manual next/prev/load requests commit at vsync.
module image_sequencer #(
  parameter int NUM_IMAGES       = 4,
  parameter int FRAMES_PER_IMAGE = 120,
  parameter int FRAME_CNT_W      = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   vsync_i,
  input  logic                   auto_en_i,
  input  logic                   next_i,
  input  logic                   prev_i,
  input  logic                   load_i,
  input  logic [3:0]             select_i,
  output logic [3:0]             image_select_o,
  output logic                   frame_start_o,
  output logic                   pending_o,
  output logic                   bad_sel_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam logic [1:0]             LAST_IDX = 2'(NUM_IMAGES - 1);
  localparam logic [2:0]             NUM_IMG  = 3'(NUM_IMAGES);
  localparam logic [FRAME_CNT_W-1:0] CNT_LAST = FRAME_CNT_W'(FRAMES_PER_IMAGE - 1);

  // Returns {valid, index}; valid only for an exact one-hot code inside the image range.
  function automatic logic [2:0] decode_sel(input logic [3:0] sel);
    logic       ok;
    logic [1:0] pos;
    case (sel)
      4'b0001: begin ok = 1'b1; pos = 2'd0; end
      4'b0010: begin ok = 1'b1; pos = 2'd1; end
      4'b0100: begin ok = 1'b1; pos = 2'd2; end
      4'b1000: begin ok = 1'b1; pos = 2'd3; end
      default: begin ok = 1'b0; pos = 2'd0; end
    endcase
    if ({1'b0, pos} >= NUM_IMG) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return {ok, pos};
  endfunction

  function automatic logic [1:0] inc_idx(input logic [1:0] i);
    return (i == LAST_IDX) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [1:0] dec_idx(input logic [1:0] i);
    return (i == 2'd0) ? LAST_IDX : i - 2'd1;
  endfunction

  logic                   vsync_q_r;
  logic [1:0]             idx_r;
  logic [FRAME_CNT_W-1:0] frame_cnt_r;
  logic                   pend_valid_r;
  logic [1:0]             pend_idx_r;

  logic                   boundary_s;
  logic [1:0]             eff_s;
  logic [2:0]             sel_dec_s;
  logic                   req_s;
  logic [1:0]             req_idx_s;
  logic                   bad_s;
  logic                   commit_s;
  logic [1:0]             idx_nxt_s;
  logic [FRAME_CNT_W-1:0] cnt_nxt_s;

  // Request decode: load beats next/prev, simultaneous next+prev is dropped.
  always_comb begin
    boundary_s = vsync_q_r & ~vsync_i;
    eff_s      = pend_valid_r ? pend_idx_r : idx_r;
    sel_dec_s  = decode_sel(select_i);
    req_s      = 1'b0;
    req_idx_s  = eff_s;
    bad_s      = 1'b0;
    if (load_i) begin
      if (sel_dec_s[2]) begin
        req_s     = 1'b1;
        req_idx_s = sel_dec_s[1:0];
      end else begin
        bad_s = 1'b1;
      end
    end else if (next_i && !prev_i) begin
      req_s     = 1'b1;
      req_idx_s = inc_idx(eff_s);
    end else if (prev_i && !next_i) begin
      req_s     = 1'b1;
      req_idx_s = dec_idx(eff_s);
    end else begin
      req_s = 1'b0;
    end
  end

  // Boundary processing: a pending manual commit replaces the auto step.
  always_comb begin
    idx_nxt_s = idx_r;
    cnt_nxt_s = frame_cnt_r;
    commit_s  = 1'b0;
    if (boundary_s) begin
      if (pend_valid_r) begin
        idx_nxt_s = pend_idx_r;
        cnt_nxt_s = '0;
        commit_s  = 1'b1;
      end else if (auto_en_i) begin
        if (frame_cnt_r == CNT_LAST) begin
          idx_nxt_s = inc_idx(idx_r);
          cnt_nxt_s = '0;
        end else begin
          cnt_nxt_s = frame_cnt_r + FRAME_CNT_W'(1);
        end
      end else begin
        cnt_nxt_s = frame_cnt_r;
      end
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // State and registered outputs; vsync_q clears in reset so a vsync already low at release is not a fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q_r      <= 1'b0;
      idx_r          <= 2'd0;
      frame_cnt_r    <= '0;
      pend_valid_r   <= 1'b0;
      pend_idx_r     <= 2'd0;
      image_select_o <= 4'b0001;
      frame_start_o  <= 1'b0;
      bad_sel_o      <= 1'b0;
    end else begin
      vsync_q_r      <= vsync_i;
      idx_r          <= idx_nxt_s;
      frame_cnt_r    <= cnt_nxt_s;
      image_select_o <= 4'b0001 << idx_nxt_s;
      frame_start_o  <= boundary_s;
      bad_sel_o      <= bad_s;
      if (req_s) begin
        pend_valid_r <= 1'b1;
        pend_idx_r   <= req_idx_s;
      end else if (commit_s) begin
        pend_valid_r <= 1'b0;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  assign pending_o   = pend_valid_r;
  assign frame_cnt_o = frame_cnt_r;

endmodule

// File: tb/tb_image_sequencer.sv
// Bench for image_sequencer: two instances (4 images/3 frames, 3 images/1 frame) checked
// every cycle against a behavioural model, plus hand-computed literal expectations.
module tb_image_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync = 1'b1;
  logic auto_en = 1'b0;
  logic next = 1'b0;
  logic prev = 1'b0;
  logic load = 1'b0;
  logic [3:0] sel = 4'b0000;

  logic [3:0] sel_a, sel_b;
  logic       fs_a, fs_b, pend_a, pend_b, bad_a, bad_b;
  logic [7:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;
  int fs_count = 0;

  always #5 clk = ~clk;

  image_sequencer #(.NUM_IMAGES(4), .FRAMES_PER_IMAGE(3), .FRAME_CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .vsync_i(vsync), .auto_en_i(auto_en),
    .next_i(next), .prev_i(prev), .load_i(load), .select_i(sel),
    .image_select_o(sel_a), .frame_start_o(fs_a), .pending_o(pend_a),
    .bad_sel_o(bad_a), .frame_cnt_o(cnt_a));

  image_sequencer #(.NUM_IMAGES(3), .FRAMES_PER_IMAGE(1), .FRAME_CNT_W(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .vsync_i(vsync), .auto_en_i(auto_en),
    .next_i(next), .prev_i(prev), .load_i(load), .select_i(sel),
    .image_select_o(sel_b), .frame_start_o(fs_b), .pending_o(pend_b),
    .bad_sel_o(bad_b), .frame_cnt_o(cnt_b));

  // Model state per instance: 0 = dut_a, 1 = dut_b
  int mn [2] = '{4, 3};
  int mf [2] = '{3, 1};
  int m_idx [2], m_cnt [2], m_pv [2], m_pi [2], m_prev [2], m_fs [2], m_bad [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: updated once per rising edge from the inputs held since the falling edge
  initial begin
    int bnd, acc, nw, bad, eff, pos, ones;
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_pv[k] = 0; m_pi[k] = 0;
      m_prev[k] = 0; m_fs[k] = 0; m_bad[k] = 0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_idx[k] = 0; m_cnt[k] = 0; m_pv[k] = 0; m_pi[k] = 0;
          m_prev[k] = 0; m_fs[k] = 0; m_bad[k] = 0;
        end else begin
          bnd = (m_prev[k] == 1 && vsync == 1'b0) ? 1 : 0;
          eff = (m_pv[k] != 0) ? m_pi[k] : m_idx[k];
          acc = 0; nw = 0; bad = 0;
          if (load) begin
            ones = 0; pos = 0;
            for (int b = 0; b < 4; b++) if (sel[b]) begin ones++; pos = b; end
            if (ones == 1 && pos < mn[k]) begin acc = 1; nw = pos; end
            else bad = 1;
          end else if (next && !prev) begin
            acc = 1; nw = (eff + 1) % mn[k];
          end else if (prev && !next) begin
            acc = 1; nw = (eff + mn[k] - 1) % mn[k];
          end
          if (bnd != 0) begin
            if (m_pv[k] != 0) begin
              m_idx[k] = m_pi[k]; m_cnt[k] = 0; m_pv[k] = 0;
            end else if (auto_en) begin
              if (m_cnt[k] + 1 == mf[k]) begin
                m_idx[k] = (m_idx[k] + 1) % mn[k]; m_cnt[k] = 0;
              end else begin
                m_cnt[k] = m_cnt[k] + 1;
              end
            end
          end
          if (acc != 0) begin m_pi[k] = nw; m_pv[k] = 1; end
          m_fs[k] = bnd;
          m_bad[k] = bad;
          m_prev[k] = vsync;
        end
      end
    end
  end

  // Compare process: every cycle, shortly after the rising edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("a_sel",  sel_a,  1 << m_idx[0]);
      chk("a_fs",   fs_a,   m_fs[0]);
      chk("a_pend", pend_a, m_pv[0]);
      chk("a_bad",  bad_a,  m_bad[0]);
      chk("a_cnt",  cnt_a,  m_cnt[0]);
      chk("b_sel",  sel_b,  1 << m_idx[1]);
      chk("b_fs",   fs_b,   m_fs[1]);
      chk("b_pend", pend_b, m_pv[1]);
      chk("b_bad",  bad_b,  m_bad[1]);
      chk("b_cnt",  cnt_b,  m_cnt[1]);
      if (fs_a) fs_count++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vsync = 1'b1; next = 1'b0; prev = 1'b0; load = 1'b0; sel = 4'b0000;
    cyc(2);
    rst = 1'b0;
    cyc(2);
  endtask

  // One-cycle request; returns at the falling edge where its effect is visible
  task automatic req(input logic n, input logic p, input logic l, input logic [3:0] s);
    @(negedge clk);
    next = n; prev = p; load = l; sel = s;
    @(negedge clk);
    next = 1'b0; prev = 1'b0; load = 1'b0; sel = 4'b0000;
  endtask

  // One vsync low pulse; returns with the boundary already processed
  task automatic frame();
    @(negedge clk);
    vsync = 1'b0;
    cyc(2);
    vsync = 1'b1;
    cyc(3);
  endtask

  initial begin
    int fs0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("reset_sel", sel_a, 4'b0001);
    chk("reset_cnt", cnt_a, 0);
    chk("reset_pend", pend_a, 0);

    // 1: auto advance every 3 frames (dut_b every frame, 3 images)
    auto_en = 1'b1;
    fs0 = fs_count;
    frame(); frame();
    chk("auto_hold2", sel_a, 4'b0001);
    chk("auto_cnt2", cnt_a, 2);
    frame();
    chk("auto_step3", sel_a, 4'b0010);
    chk("auto_b3", sel_b, 4'b0001);
    chk("model_pin_a", 1 << m_idx[0], 4'b0010);
    repeat (9) frame();
    chk("auto_wrap12", sel_a, 4'b0001);
    chk("auto_b12", sel_b, 4'b0001);
    chk("auto_fs12", fs_count - fs0, 12);

    // 2: deferred manual
    do_reset();
    auto_en = 1'b0;
    cyc(2);
    req(1'b1, 1'b0, 1'b0, 4'b0000);
    chk("next_pend", pend_a, 1);
    chk("next_defer", sel_a, 4'b0001);
    frame();
    chk("next_commit", sel_a, 4'b0010);
    chk("next_pend_clr", pend_a, 0);
    do_reset();
    req(1'b0, 1'b1, 1'b0, 4'b0000);
    req(1'b0, 1'b1, 1'b0, 4'b0000);
    frame();
    chk("prev2_a", sel_a, 4'b0100);
    chk("prev2_b", sel_b, 4'b0010);

    // 3: load and rejection
    req(1'b0, 1'b0, 1'b1, 4'b1000);
    chk("load8_pend", pend_a, 1);
    chk("load8_b_bad", bad_b, 1);
    chk("load8_b_pend", pend_b, 0);
    frame();
    chk("load8_commit", sel_a, 4'b1000);
    chk("load8_b_keep", sel_b, 4'b0010);
    req(1'b0, 1'b0, 1'b1, 4'b0110);
    chk("bad_pulse", bad_a, 1);
    chk("bad_nopend", pend_a, 0);
    cyc(1);
    chk("bad_once", bad_a, 0);

    // 4: collisions
    req(1'b1, 1'b1, 1'b0, 4'b0000);
    chk("np_ignored", pend_a, 0);
    req(1'b1, 1'b0, 1'b1, 4'b0100);
    frame();
    chk("load_over_next", sel_a, 4'b0100);
    req(1'b0, 1'b0, 1'b1, 4'b0010);
    @(negedge clk);
    vsync = 1'b0; next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("bnd_commit", sel_a, 4'b0010);
    chk("bnd_still_pend", pend_a, 1);
    cyc(1);
    vsync = 1'b1;
    cyc(3);
    frame();
    chk("bnd_next_commit", sel_a, 4'b0100);
    chk("bnd_pend_clr", pend_a, 0);

    // 5: manual pre-empts auto
    do_reset();
    auto_en = 1'b1;
    frame(); frame();
    chk("pre_cnt2", cnt_a, 2);
    req(1'b1, 1'b0, 1'b0, 4'b0000);
    frame();
    chk("pre_sel", sel_a, 4'b0010);
    chk("pre_cnt0", cnt_a, 0);
    frame();
    chk("pre_cnt1", cnt_a, 1);
    chk("pre_noextra", sel_a, 4'b0010);

    // 6: reset mid-operation with vsync held low across release
    do_reset();
    auto_en = 1'b0;
    req(1'b0, 1'b0, 1'b1, 4'b0100);
    frame();
    req(1'b1, 1'b0, 1'b0, 4'b0000);
    chk("rst_pre_sel", sel_a, 4'b0100);
    chk("rst_pre_pend", pend_a, 1);
    @(negedge clk);
    rst = 1'b1; vsync = 1'b0;
    @(negedge clk);
    chk("rst_sel", sel_a, 4'b0001);
    chk("rst_pend", pend_a, 0);
    chk("rst_cnt", cnt_a, 0);
    cyc(1);
    rst = 1'b0;
    fs0 = fs_count;
    cyc(4);
    chk("rst_no_bnd", fs_count - fs0, 0);
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    cyc(2);
    chk("rst_bnd_after", fs_count - fs0, 1);
    vsync = 1'b1;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
